// File: rtl/regfile_2r1w_sb.sv
// Two-read, one-write register file with same-cycle write bypass and a per-register
// busy scoreboard (claim at decode, release at writeback).
module regfile_2r1w_sb #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter bit          ZERO_R0 = 1'b0,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic             stall,
  output logic             claim_err,
  output logic [DEPTH-1:0] busy_vec
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             claim_err_q, claim_err_d;

  logic             wr_addr_ok, claim_addr_ok;
  logic             wr_ok, claim_ok;
  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_busy [2];
  logic             rd_addr_ok [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  // An address is usable when in range and not the hardwired zero register.
  always_comb begin
    wr_addr_ok    = (32'(wr_addr) < DEPTH) && !(ZERO_R0 && (wr_addr == '0));
    claim_addr_ok = (32'(claim_addr) < DEPTH) && !(ZERO_R0 && (claim_addr == '0));
    for (int p = 0; p < 2; p++) begin
      rd_addr_ok[p] = (32'(rd_addr[p]) < DEPTH) && !(ZERO_R0 && (rd_addr[p] == '0));
    end
  end

  assign wr_ok    = wr_en && wr_addr_ok && !reset;
  assign claim_ok = claim_en && claim_addr_ok && !reset;

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Claim beats release: a same-cycle claim and write leave the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[claim_addr] = 1'b1;
    end
  end

  always_comb begin
    claim_err_d = claim_ok && busy_q[claim_addr] && !(wr_ok && (wr_addr == claim_addr));
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (!reset && rd_addr_ok[p]) begin
        if (BYPASS && wr_ok && (wr_addr == rd_addr[p])) begin
          rd_data[p] = wr_data;
          rd_busy[p] = 1'b0;
        end else begin
          rd_data[p] = mem_q[rd_addr[p]];
          rd_busy[p] = busy_q[rd_addr[p]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      busy_q      <= busy_d;
      claim_err_q <= claim_err_d;
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign busy_a    = rd_busy[0];
  assign busy_b    = rd_busy[1];
  assign stall     = rd_busy[0] | rd_busy[1];
  assign claim_err = claim_err_q;
  assign busy_vec  = reset ? '0 : busy_q;

endmodule
